fetch_ctrl: RTL and testbench

Sequencing controller for the instruction-fetch stage. It holds the PC after reset and stalls fetch on load-use hazards and instruction-memory wait states. It redirects the PC on taken branches and kills wrong-path instructions, and it supports halt/resume. It sits beside the fetch stage and drives its PC-select mux, PC write enable and IF/ID latch controls, plus the ID/EX bubble.

---
 rtl/fetch_ctrl_pkg.sv | 19 +
 rtl/fetch_ctrl_hazard_detect.sv | 23 ++
 rtl/fetch_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_fetch_ctrl.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_ctrl_pkg.sv
// fetch_ctrl_pkg
// Shared definitions for the instruction-fetch sequencing controller:
// FSM state encodings, the hardwired-zero register index and counter widths.
package fetch_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_WAIT = 2'd2,
    ST_HALT = 2'd3
  } state_e;

  localparam logic [4:0] REG_ZERO   = 5'd0;

  localparam int BOOT_CNT_W = 8;
  localparam int WAIT_CNT_W = 8;
  localparam int PERF_CNT_W = 32;

endpackage

// File: rtl/fetch_ctrl_hazard_detect.sv
// hazard_detect
// Combinational load-use detector. Flags when the load in EX writes a
// register that the instruction in ID reads. Register 0 never creates a
// hazard because it is hardwired to zero.
// Ports:
//   ex_memread  - instruction in EX is a load
//   ex_rt       - load destination register
//   id_rs/id_rt - source registers of the instruction in ID
//   load_use    - hazard present this cycle
module hazard_detect
  import fetch_ctrl_pkg::*;
(
  input  logic       ex_memread,
  input  logic [4:0] ex_rt,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  output logic       load_use
);

  assign load_use = ex_memread && (ex_rt != REG_ZERO) &&
                    ((ex_rt == id_rs) || (ex_rt == id_rt));

endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl
// Sequencing controller for the instruction-fetch stage: holds the PC after
// reset, stalls on load-use hazards and imem wait states, redirects on taken
// branches and supports halt/resume.
//
// Optional feature: define FETCH_CTRL_PERF_EN to build the saturating
// stall_cycles performance counter; otherwise stall_cycles is tied to 0.
//
// Ports:
//   clk, reset (async, active-low)
//   imem_valid, ex_branch_taken, ex_branch_target, ex_memread, ex_rt,
//   id_rs, id_rt, halt_req, resume                         - inputs
//   pcsrc, if_a, pc_en, ifid_en, ifid_flush, idex_bubble   - pipeline controls
//   fetch_err (sticky timeout), state, stall_cycles        - status
//
// state | meaning
// ------+---------------------------------------------------------------
// BOOT  | PC held after reset for BOOT_CYCLES cycles
// RUN   | normal fetch; branch redirect / load-use stall handled here
// WAIT  | instruction memory not ready; timeout after WAIT_MAX cycles
// HALT  | fetch stopped until resume pulse
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter int unsigned BOOT_CYCLES = 4,
  parameter int unsigned WAIT_MAX    = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        imem_valid,
  input  logic        ex_branch_taken,
  input  logic [31:0] ex_branch_target,
  input  logic        ex_memread,
  input  logic [4:0]  ex_rt,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        halt_req,
  input  logic        resume,
  output logic        pcsrc,
  output logic [31:0] if_a,
  output logic        pc_en,
  output logic        ifid_en,
  output logic        ifid_flush,
  output logic        idex_bubble,
  output logic        fetch_err,
  output logic [1:0]  state,
  output logic [31:0] stall_cycles
);

  localparam logic [BOOT_CNT_W-1:0] BOOT_LOAD = BOOT_CNT_W'(BOOT_CYCLES - 1);
  localparam logic [WAIT_CNT_W-1:0] WAIT_LAST = WAIT_CNT_W'(WAIT_MAX - 1);

  state_e                state_q, state_d;
  logic [BOOT_CNT_W-1:0] boot_cnt_q, boot_cnt_d;
  logic [WAIT_CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic                  fetch_err_q, fetch_err_d;
  logic                  load_use;

  hazard_detect u_hazard_detect (
    .ex_memread (ex_memread),
    .ex_rt      (ex_rt),
    .id_rs      (id_rs),
    .id_rt      (id_rt),
    .load_use   (load_use)
  );

  always_comb begin
    state_d     = state_q;
    boot_cnt_d  = boot_cnt_q;
    wait_cnt_d  = wait_cnt_q;
    fetch_err_d = fetch_err_q;
    pcsrc       = 1'b0;
    pc_en       = 1'b0;
    ifid_en     = 1'b0;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;

    case (state_q)
      ST_BOOT: begin
        ifid_flush  = 1'b1;
        idex_bubble = 1'b1;
        if (boot_cnt_q == '0) begin
          state_d = ST_RUN;
        end else begin
          boot_cnt_d = boot_cnt_q - 1'b1;
        end
      end

      ST_RUN: begin
        if (ex_branch_taken) begin
          // Branch wins over a simultaneous load-use: the dependent
          // instruction is on the wrong path and gets flushed anyway.
          pcsrc       = 1'b1;
          pc_en       = 1'b1;
          ifid_en     = 1'b1;
          ifid_flush  = 1'b1;
          idex_bubble = 1'b1;
        end else if (load_use) begin
          idex_bubble = 1'b1;
        end else if (!imem_valid) begin
          ifid_flush = 1'b1;
          wait_cnt_d = '0;
          state_d    = ST_WAIT;
        end else if (halt_req) begin
          ifid_flush = 1'b1;
          state_d    = ST_HALT;
        end else begin
          pc_en   = 1'b1;
          ifid_en = 1'b1;
        end
      end

      ST_WAIT: begin
        ifid_flush = 1'b1;
        wait_cnt_d = wait_cnt_q + 1'b1;
        if (ex_branch_taken) begin
          // Pending fetch is abandoned; the redirected fetch starts in RUN.
          pcsrc       = 1'b1;
          pc_en       = 1'b1;
          idex_bubble = 1'b1;
          state_d     = ST_RUN;
        end else if (imem_valid) begin
          pc_en      = 1'b1;
          ifid_en    = 1'b1;
          ifid_flush = 1'b0;
          state_d    = ST_RUN;
        end else if (wait_cnt_q == WAIT_LAST) begin
          fetch_err_d = 1'b1;
          state_d     = ST_HALT;
        end
      end

      ST_HALT: begin
        ifid_flush = 1'b1;
        if (resume) begin
          fetch_err_d = 1'b0;
          state_d     = ST_RUN;
        end
      end

      default: begin
        state_d = ST_BOOT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_BOOT;
      boot_cnt_q  <= BOOT_LOAD;
      wait_cnt_q  <= '0;
      fetch_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      boot_cnt_q  <= boot_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
      fetch_err_q <= fetch_err_d;
    end
  end

  assign if_a      = pcsrc ? ex_branch_target : 32'd0;
  assign fetch_err = fetch_err_q;
  assign state     = state_q;

`ifdef FETCH_CTRL_PERF_EN
  logic [PERF_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (((state_q == ST_RUN) || (state_q == ST_WAIT)) && !pc_en &&
        (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cycles = stall_cnt_q;
`else
  assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl
// Directed bench for fetch_ctrl with BOOT_CYCLES=4, WAIT_MAX=16.
// Inputs change 1 time unit after the rising edge; outputs are sampled a
// further 1 unit later, well before the next edge.
module tb_fetch_ctrl;

  logic        clk;
  logic        reset;
  logic        imem_valid;
  logic        ex_branch_taken;
  logic [31:0] ex_branch_target;
  logic        ex_memread;
  logic [4:0]  ex_rt;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic        halt_req;
  logic        resume;
  logic        pcsrc;
  logic [31:0] if_a;
  logic        pc_en;
  logic        ifid_en;
  logic        ifid_flush;
  logic        idex_bubble;
  logic        fetch_err;
  logic [1:0]  state;
  logic [31:0] stall_cycles;

  int checks   = 0;
  int failures = 0;
  int exp_stall = 0;

  fetch_ctrl #(.BOOT_CYCLES(4), .WAIT_MAX(16)) dut (
    .clk              (clk),
    .reset            (reset),
    .imem_valid       (imem_valid),
    .ex_branch_taken  (ex_branch_taken),
    .ex_branch_target (ex_branch_target),
    .ex_memread       (ex_memread),
    .ex_rt            (ex_rt),
    .id_rs            (id_rs),
    .id_rt            (id_rt),
    .halt_req         (halt_req),
    .resume           (resume),
    .pcsrc            (pcsrc),
    .if_a             (if_a),
    .pc_en            (pc_en),
    .ifid_en          (ifid_en),
    .ifid_flush       (ifid_flush),
    .idex_bubble      (idex_bubble),
    .fetch_err        (fetch_err),
    .state            (state),
    .stall_cycles     (stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    imem_valid       = 1'b1;
    ex_branch_taken  = 1'b0;
    ex_branch_target = 32'd0;
    ex_memread       = 1'b0;
    ex_rt            = 5'd0;
    id_rs            = 5'd0;
    id_rt            = 5'd0;
    halt_req         = 1'b0;
    resume           = 1'b0;
  endtask

  task automatic chk_stall(input string tag);
`ifdef FETCH_CTRL_PERF_EN
    chk(tag, stall_cycles, 32'(exp_stall));
`else
    chk(tag, stall_cycles, 32'd0);
`endif
  endtask

  task automatic chk_reset_vals(input string pfx);
    chk({pfx, "_state"},   {30'd0, state}, 32'd0);
    chk({pfx, "_pc_en"},   {31'd0, pc_en}, 32'd0);
    chk({pfx, "_ifid_en"}, {31'd0, ifid_en}, 32'd0);
    chk({pfx, "_flush"},   {31'd0, ifid_flush}, 32'd1);
    chk({pfx, "_bubble"},  {31'd0, idex_bubble}, 32'd1);
    chk({pfx, "_pcsrc"},   {31'd0, pcsrc}, 32'd0);
    chk({pfx, "_if_a"},    if_a, 32'd0);
    chk({pfx, "_err"},     {31'd0, fetch_err}, 32'd0);
    chk({pfx, "_stall"},   stall_cycles, 32'd0);
  endtask

  initial begin
    idle_inputs();
    reset = 1'b0;
    #2;
    chk_reset_vals("rst");

    // Boot: 4 cycles with PC held, then RUN
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      chk("boot_pc_en", {31'd0, pc_en}, 32'd0);
      chk("boot_state", {30'd0, state}, 32'd0);
      step();
    end
    #1;
    chk("run_state", {30'd0, state}, 32'd1);
    chk("run_pc_en", {31'd0, pc_en}, 32'd1);
    chk("run_ifid_en", {31'd0, ifid_en}, 32'd1);
    chk("run_flush", {31'd0, ifid_flush}, 32'd0);
    step();

    // Load-use on rs
    ex_memread = 1'b1; ex_rt = 5'd5; id_rs = 5'd5; id_rt = 5'd1;
    #1;
    chk("lu_pc_en", {31'd0, pc_en}, 32'd0);
    chk("lu_ifid_en", {31'd0, ifid_en}, 32'd0);
    chk("lu_bubble", {31'd0, idex_bubble}, 32'd1);
    chk("lu_flush", {31'd0, ifid_flush}, 32'd0);
    exp_stall++;
    step();
    idle_inputs();
    #1;
    chk("lu_after_pc_en", {31'd0, pc_en}, 32'd1);
    chk("lu_after_bubble", {31'd0, idex_bubble}, 32'd0);
    chk("lu_after_state", {30'd0, state}, 32'd1);
    step();

    // Load to r0: no hazard
    ex_memread = 1'b1; ex_rt = 5'd0; id_rs = 5'd0; id_rt = 5'd0;
    #1;
    chk("lu_r0_pc_en", {31'd0, pc_en}, 32'd1);
    chk("lu_r0_bubble", {31'd0, idex_bubble}, 32'd0);
    step();

    // Load-use on rt
    ex_memread = 1'b1; ex_rt = 5'd7; id_rs = 5'd2; id_rt = 5'd7;
    #1;
    chk("lu_rt_pc_en", {31'd0, pc_en}, 32'd0);
    exp_stall++;
    step();

    // Branch together with load-use: branch wins
    ex_branch_taken = 1'b1; ex_branch_target = 32'h40;
    ex_memread = 1'b1; ex_rt = 5'd5; id_rs = 5'd5;
    #1;
    chk("br_pcsrc", {31'd0, pcsrc}, 32'd1);
    chk("br_if_a", if_a, 32'h40);
    chk("br_pc_en", {31'd0, pc_en}, 32'd1);
    chk("br_ifid_en", {31'd0, ifid_en}, 32'd1);
    chk("br_flush", {31'd0, ifid_flush}, 32'd1);
    chk("br_bubble", {31'd0, idex_bubble}, 32'd1);
    step();
    idle_inputs();
    ex_branch_target = 32'h40;
    #1;
    chk("br_after_pcsrc", {31'd0, pcsrc}, 32'd0);
    chk("br_after_if_a", if_a, 32'd0);
    chk("br_after_state", {30'd0, state}, 32'd1);
    chk_stall("stall_a");
    step();

    // imem_valid low for 3 cycles
    imem_valid = 1'b0;
    #1;
    chk("w1_pc_en", {31'd0, pc_en}, 32'd0);
    chk("w1_flush", {31'd0, ifid_flush}, 32'd1);
    step();
    #1;
    chk("w2_state", {30'd0, state}, 32'd2);
    chk("w2_flush", {31'd0, ifid_flush}, 32'd1);
    step();
    #1;
    chk("w3_state", {30'd0, state}, 32'd2);
    step();
    imem_valid = 1'b1;
    #1;
    chk("w4_pc_en", {31'd0, pc_en}, 32'd1);
    chk("w4_ifid_en", {31'd0, ifid_en}, 32'd1);
    chk("w4_flush", {31'd0, ifid_flush}, 32'd0);
    exp_stall += 3;
    step();
    #1;
    chk("w_done_state", {30'd0, state}, 32'd1);
    chk_stall("stall_wait3");
    step();

    // Branch while waiting abandons the fetch
    imem_valid = 1'b0;
    exp_stall++;
    step();
    ex_branch_taken = 1'b1; ex_branch_target = 32'h80;
    #1;
    chk("wbr_state", {30'd0, state}, 32'd2);
    chk("wbr_pcsrc", {31'd0, pcsrc}, 32'd1);
    chk("wbr_if_a", if_a, 32'h80);
    chk("wbr_pc_en", {31'd0, pc_en}, 32'd1);
    step();
    idle_inputs();
    #1;
    chk("wbr_after_state", {30'd0, state}, 32'd1);
    step();

    // Timeout: imem_valid held low
    imem_valid = 1'b0;
    exp_stall++;
    step();
    for (int i = 0; i < 16; i++) begin
      #1;
      chk("to_wait_state", {30'd0, state}, 32'd2);
      chk("to_wait_err", {31'd0, fetch_err}, 32'd0);
      step();
    end
    exp_stall += 16;
    #1;
    chk("to_state", {30'd0, state}, 32'd3);
    chk("to_err", {31'd0, fetch_err}, 32'd1);
    chk("to_pc_en", {31'd0, pc_en}, 32'd0);
    chk("to_flush", {31'd0, ifid_flush}, 32'd1);
    chk_stall("stall_timeout");
    step();
    imem_valid = 1'b1;
    resume = 1'b1;
    #1;
    chk("res_err_before", {31'd0, fetch_err}, 32'd1);
    step();
    resume = 1'b0;
    #1;
    chk("res_state", {30'd0, state}, 32'd1);
    chk("res_err", {31'd0, fetch_err}, 32'd0);
    chk("res_pc_en", {31'd0, pc_en}, 32'd1);
    step();

    // halt_req, then resume with halt_req still high
    halt_req = 1'b1;
    #1;
    chk("h_pc_en", {31'd0, pc_en}, 32'd0);
    chk("h_flush", {31'd0, ifid_flush}, 32'd1);
    exp_stall++;
    step();
    #1;
    chk("h_state", {30'd0, state}, 32'd3);
    chk_stall("stall_halt");
    resume = 1'b1;
    step();
    resume = 1'b0;
    #1;
    chk("h_again_state", {30'd0, state}, 32'd1);
    chk("h_again_pc_en", {31'd0, pc_en}, 32'd0);
    exp_stall++;
    step();
    #1;
    chk("h_again_halt", {30'd0, state}, 32'd3);
    chk_stall("stall_halt2");

    // Asynchronous reset mid-HALT
    ex_branch_taken = 1'b1; ex_branch_target = 32'hDEAD_BEEF;
    #1;
    reset = 1'b0;
    #1;
    chk_reset_vals("rst_mid");
    idle_inputs();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
